// File: rtl/csr_interrupt_unit.sv
// mip/mie/mideleg CSRs, fixed-priority interrupt selection and trap request handshake (IDLE/REQ/HOLD).
// Optional macro IRQ_SYNC_EN inserts 2-flop synchronisers ahead of the interrupt input register.
module csr_interrupt_unit #(
  parameter int          NUM_CUSTOM_IRQ   = 4,
  parameter logic [15:0] CUSTOM_EDGE_MASK = 16'h0000,
  parameter int          ECODE_W          = 5,
  localparam int         CUST_W           = (NUM_CUSTOM_IRQ > 0) ? NUM_CUSTOM_IRQ : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               csr_wr_en,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  input  logic [1:0]         priv_mode,
  input  logic               mstatus_mie,
  input  logic               mstatus_sie,
  input  logic               m_ext_irq,
  input  logic               m_timer_irq,
  input  logic               m_soft_irq,
  input  logic               s_ext_irq,
  input  logic [CUST_W-1:0]  custom_irq,
  output logic               irq_req,
  output logic [ECODE_W-1:0] irq_cause,
  output logic               irq_to_s,
  input  logic               irq_ack
);

  localparam logic [15:0] CUST_IMPL  = 16'((33'h1 << NUM_CUSTOM_IRQ) - 33'h1);
  localparam logic [15:0] CUST_EDGE  = CUSTOM_EDGE_MASK & CUST_IMPL;
  localparam logic [31:0] MIE_MASK   = {CUST_IMPL, 16'h0AAA};
  localparam logic [31:0] DELEG_MASK = 32'h0000_0222;
  localparam logic [1:0]  PRIV_U     = 2'b00;
  localparam logic [1:0]  PRIV_S     = 2'b01;
  localparam logic [1:0]  PRIV_M     = 2'b11;
  localparam int          STD_PRIO [6] = '{11, 3, 7, 9, 1, 5};

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cause_q, cause_d;
  logic        to_s_q, to_s_d;
  logic [19:0] in_q;
  logic [15:0] edge_q, edge_d;
  logic        ssip_q, ssip_d, stip_q, stip_d, seip_sw_q, seip_sw_d;
  logic [31:0] mie_q, mie_d, deleg_q, deleg_d;

  logic [15:0] cust_raw;
  logic [19:0] line_raw, line_smp;
  logic [15:0] edge_set;
  logic [31:0] mip, takeable;
  logic        m_ok, s_ok, sel_vld;
  logic [4:0]  sel_idx;
  logic        mip_wr, mie_wr, deleg_wr;

  always_comb begin
    cust_raw = '0;
    for (int i = 0; i < NUM_CUSTOM_IRQ; i++) cust_raw[i] = custom_irq[i];
  end

  // {custom[15:0], s_ext, m_soft, m_timer, m_ext}
  assign line_raw = {cust_raw, s_ext_irq, m_soft_irq, m_timer_irq, m_ext_irq};

`ifdef IRQ_SYNC_EN
  logic [19:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= line_raw;
      sync2_q <= sync1_q;
    end
  end
  assign line_smp = sync2_q;
`else
  assign line_smp = line_raw;
`endif

  assign edge_set = line_smp[19:4] & ~in_q[19:4] & CUST_EDGE;
  assign mip_wr   = csr_wr_en && (csr_addr == 12'h344);
  assign mie_wr   = csr_wr_en && (csr_addr == 12'h304);
  assign deleg_wr = csr_wr_en && (csr_addr == 12'h303);

  always_comb begin
    ssip_d    = ssip_q;
    stip_d    = stip_q;
    seip_sw_d = seip_sw_q;
    edge_d    = edge_q;
    mie_d     = mie_q;
    deleg_d   = deleg_q;
    if (mip_wr) begin
      ssip_d    = csr_wdata[1];
      stip_d    = csr_wdata[5];
      seip_sw_d = csr_wdata[9];
      edge_d    = edge_q & csr_wdata[31:16];
    end
    // a fresh edge overrides a same-cycle software clear
    edge_d = (edge_d | edge_set) & CUST_EDGE;
    if (mie_wr)   mie_d   = csr_wdata & MIE_MASK;
    if (deleg_wr) deleg_d = csr_wdata & DELEG_MASK;
  end

  always_comb begin
    mip         = '0;
    mip[1]      = ssip_q;
    mip[3]      = in_q[2];
    mip[5]      = stip_q;
    mip[7]      = in_q[1];
    mip[9]      = in_q[3] | seip_sw_q;
    mip[11]     = in_q[0];
    mip[31:16]  = ((in_q[19:4] & ~CUST_EDGE) | edge_q) & CUST_IMPL;
  end

  assign m_ok     = (priv_mode != PRIV_M) || mstatus_mie;
  assign s_ok     = (priv_mode == PRIV_U) || ((priv_mode == PRIV_S) && mstatus_sie);
  assign takeable = mip & mie_q & ((deleg_q & {32{s_ok}}) | (~deleg_q & {32{m_ok}}));

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < 6; k++) begin
      if (!sel_vld && takeable[STD_PRIO[k]]) begin
        sel_vld = 1'b1;
        sel_idx = 5'(STD_PRIO[k]);
      end
    end
    for (int i = 16; i < 32; i++) begin
      if (!sel_vld && takeable[i]) begin
        sel_vld = 1'b1;
        sel_idx = 5'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    to_s_d  = to_s_q;
    case (state_q)
      IDLE: if (sel_vld) begin
        state_d = REQ;
        cause_d = sel_idx;
        to_s_d  = deleg_q[sel_idx];
      end
      // withdraw silently if the chosen source stops being takeable before the ack
      REQ: if (irq_ack) state_d = HOLD;
           else if (!takeable[cause_q]) state_d = IDLE;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cause_q   <= '0;
      to_s_q    <= 1'b0;
      in_q      <= '0;
      edge_q    <= '0;
      ssip_q    <= 1'b0;
      stip_q    <= 1'b0;
      seip_sw_q <= 1'b0;
      mie_q     <= '0;
      deleg_q   <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      to_s_q    <= to_s_d;
      in_q      <= line_smp;
      edge_q    <= edge_d;
      ssip_q    <= ssip_d;
      stip_q    <= stip_d;
      seip_sw_q <= seip_sw_d;
      mie_q     <= mie_d;
      deleg_q   <= deleg_d;
    end
  end

  always_comb begin
    case (csr_addr)
      12'h303: csr_rdata = deleg_q;
      12'h304: csr_rdata = mie_q;
      12'h344: csr_rdata = mip;
      default: csr_rdata = '0;
    endcase
  end

  assign irq_req   = (state_q == REQ);
  assign irq_cause = ECODE_W'(cause_q);
  assign irq_to_s  = to_s_q;

endmodule

// File: tb/tb_csr_interrupt_unit.sv
// Bench for csr_interrupt_unit: CSR vector table, directed handshake/edge sequences, randomized run vs reference model.
module tb_csr_interrupt_unit;
  localparam int          NCUST = 4;
  localparam logic [15:0] EMASK = 16'h0002;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int D = LAT - 1;
  localparam int PRIO [10] = '{11, 3, 7, 9, 1, 5, 16, 17, 18, 19};

  logic        clk = 1'b0;
  logic        rst_n, csr_wr_en, mstatus_mie, mstatus_sie;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic [1:0]  priv_mode;
  logic        m_ext_irq, m_timer_irq, m_soft_irq, s_ext_irq;
  logic [3:0]  custom_irq;
  logic        irq_req, irq_to_s, irq_ack;
  logic [4:0]  irq_cause;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  csr_interrupt_unit #(
    .NUM_CUSTOM_IRQ(NCUST), .CUSTOM_EDGE_MASK(EMASK), .ECODE_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .csr_wr_en(csr_wr_en), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .priv_mode(priv_mode),
    .mstatus_mie(mstatus_mie), .mstatus_sie(mstatus_sie), .m_ext_irq(m_ext_irq),
    .m_timer_irq(m_timer_irq), .m_soft_irq(m_soft_irq), .s_ext_irq(s_ext_irq),
    .custom_irq(custom_irq), .irq_req(irq_req), .irq_cause(irq_cause),
    .irq_to_s(irq_to_s), .irq_ack(irq_ack)
  );

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } csr_vec_t;
  csr_vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_wr_en = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    tick();
    csr_wr_en = 1'b0;
  endtask

  task automatic csr_rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    check(name, csr_rdata, exp);
  endtask

  // reference model state
  int          ms;
  logic [4:0]  mcause, first;
  logic        mtos, found, okb, do_rst, wr;
  logic [31:0] mmie, mdel, mmip, mtake;
  logic        mssip, mstip, mseip;
  logic [3:0]  mlatch;
  logic [7:0]  dl [0:4];
  logic [7:0]  lines, vis;
  int          psel, asel;

  initial begin
    rst_n = 1'b0; csr_wr_en = 1'b0; csr_addr = '0; csr_wdata = '0;
    priv_mode = 2'b11; mstatus_mie = 1'b0; mstatus_sie = 1'b0;
    m_ext_irq = 1'b0; m_timer_irq = 1'b0; m_soft_irq = 1'b0; s_ext_irq = 1'b0;
    custom_irq = '0; irq_ack = 1'b0;

    vecs[0] = '{12'h304, 32'hFFFF_FFFF, 32'h000F_0AAA};
    vecs[1] = '{12'h303, 32'hFFFF_FFFF, 32'h0000_0222};
    vecs[2] = '{12'h344, 32'hFFFF_FFFF, 32'h0000_0222};
    vecs[3] = '{12'h304, 32'h0000_0880, 32'h0000_0880};
    vecs[4] = '{12'h303, 32'h0000_0200, 32'h0000_0200};
    vecs[5] = '{12'h344, 32'h0000_0020, 32'h0000_0020};
    vecs[6] = '{12'h344, 32'h0000_0000, 32'h0000_0000};
    vecs[7] = '{12'h303, 32'h0000_0000, 32'h0000_0000};
    vecs[8] = '{12'h304, 32'h0000_0000, 32'h0000_0000};
    vecs[9] = '{12'h7C0, 32'hFFFF_FFFF, 32'h0000_0000};

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    csr_rd_chk("rst_mie", 12'h304, 32'h0);
    csr_rd_chk("rst_mideleg", 12'h303, 32'h0);
    csr_rd_chk("rst_mip", 12'h344, 32'h0);
    check("rst_req", {31'h0, irq_req}, 32'h0);
    check("rst_cause", {27'h0, irq_cause}, 32'h0);
    check("rst_to_s", {31'h0, irq_to_s}, 32'h0);

    for (int i = 0; i < 10; i++) begin
      csr_wr(vecs[i].addr, vecs[i].wdata);
      csr_rd_chk($sformatf("csr_vec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    check("table_no_req", {31'h0, irq_req}, 32'h0);

    // MTI + MEI together: MEI wins, ack then holdoff
    priv_mode = 2'b11; mstatus_mie = 1'b1;
    csr_wr(12'h304, 32'h880);
    m_timer_irq = 1'b1; m_ext_irq = 1'b1;
    repeat (LAT - 1) tick();
    check("lat_early", {31'h0, irq_req}, 32'h0);
    tick();
    check("lat_req", {31'h0, irq_req}, 32'h1);
    check("mei_cause", {27'h0, irq_cause}, 32'd11);
    check("mei_to_s", {31'h0, irq_to_s}, 32'h0);
    irq_ack = 1'b1; csr_wr_en = 1'b1; csr_addr = 12'h304; csr_wdata = 32'h0;
    tick();
    irq_ack = 1'b0; csr_wr_en = 1'b0;
    m_timer_irq = 1'b0; m_ext_irq = 1'b0;
    check("ack_drop", {31'h0, irq_req}, 32'h0);
    tick();
    check("hold_low", {31'h0, irq_req}, 32'h0);
    repeat (LAT + 1) tick();

    // delegated SEI
    csr_wr(12'h303, 32'hFFFF_FFFF);
    csr_rd_chk("deleg_rd", 12'h303, 32'h222);
    priv_mode = 2'b01; mstatus_sie = 1'b1; mstatus_mie = 1'b0;
    csr_wr(12'h304, 32'h200);
    s_ext_irq = 1'b1;
    repeat (LAT) tick();
    check("sei_req", {31'h0, irq_req}, 32'h1);
    check("sei_cause", {27'h0, irq_cause}, 32'd9);
    check("sei_to_s", {31'h0, irq_to_s}, 32'h1);
    priv_mode = 2'b11; mstatus_mie = 1'b1;
    tick();
    check("sei_m_withdraw", {31'h0, irq_req}, 32'h0);
    repeat (3) tick();
    check("sei_m_stay", {31'h0, irq_req}, 32'h0);
    s_ext_irq = 1'b0;
    csr_wr(12'h303, 32'h0);
    csr_wr(12'h304, 32'h0);
    repeat (LAT + 1) tick();

    // edge-latched custom line 1 (mip bit 17)
    priv_mode = 2'b00;
    csr_wr(12'h304, 32'h0002_0000);
    custom_irq = 4'b0010;
    tick();
    custom_irq = 4'b0000;
    repeat (LAT + 1) tick();
    csr_rd_chk("edge_latched", 12'h344, 32'h0002_0000);
    check("edge_req", {31'h0, irq_req}, 32'h1);
    check("edge_cause", {27'h0, irq_cause}, 32'd17);
    custom_irq = 4'b0010;
    repeat (LAT - 2) tick();
    csr_wr(12'h344, 32'h0);
    csr_rd_chk("edge_set_wins", 12'h344, 32'h0002_0000);
    csr_wr(12'h344, 32'h0);
    csr_rd_chk("edge_cleared", 12'h344, 32'h0);
    tick();
    check("edge_clr_noreq", {31'h0, irq_req}, 32'h0);
    custom_irq = 4'b0000;
    csr_wr(12'h304, 32'h0);
    repeat (LAT + 1) tick();

    // MTI withdrawn by clearing mie before ack
    priv_mode = 2'b11; mstatus_mie = 1'b1;
    csr_wr(12'h304, 32'h80);
    m_timer_irq = 1'b1;
    repeat (LAT) tick();
    check("mti_req", {31'h0, irq_req}, 32'h1);
    check("mti_cause", {27'h0, irq_cause}, 32'd7);
    csr_wr(12'h304, 32'h0);
    tick();
    check("mti_withdraw", {31'h0, irq_req}, 32'h0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("ack_ignored", {31'h0, irq_req}, 32'h0);
    csr_wr(12'h304, 32'h80);
    tick();
    check("mti_rearm", {31'h0, irq_req}, 32'h1);
    m_timer_irq = 1'b0;
    csr_wr(12'h304, 32'h0);

    // randomized run against the reference model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ms = 0; mcause = '0; mtos = 1'b0; mmie = '0; mdel = '0;
    mssip = 1'b0; mstip = 1'b0; mseip = 1'b0; mlatch = '0;
    for (int k = 0; k < 5; k++) dl[k] = '0;

    for (int c = 0; c < 400; c++) begin
      do_rst = (c == 200);
      lines  = do_rst ? 8'h0 : 8'($urandom);
      {custom_irq, s_ext_irq, m_soft_irq, m_timer_irq, m_ext_irq} = lines;
      psel = $urandom_range(0, 2);
      priv_mode   = (psel == 2) ? 2'b11 : 2'(psel);
      mstatus_mie = 1'($urandom);
      mstatus_sie = 1'($urandom);
      irq_ack     = ($urandom_range(0, 2) == 0);
      wr          = !do_rst && ($urandom_range(0, 3) == 0);
      asel        = $urandom_range(0, 2);
      csr_wr_en   = wr;
      csr_addr    = (asel == 0) ? 12'h303 : (asel == 1) ? 12'h304 : 12'h344;
      csr_wdata   = $urandom;
      rst_n       = !do_rst;
      dl[0]       = lines;

      vis = dl[D];
      mmip = '0;
      mmip[11] = vis[0]; mmip[7] = vis[1]; mmip[3] = vis[2];
      mmip[9]  = vis[3] | mseip; mmip[1] = mssip; mmip[5] = mstip;
      for (int i = 0; i < 4; i++) mmip[16+i] = EMASK[i] ? mlatch[i] : vis[4+i];

      #1;
      check("rnd_req", {31'h0, irq_req}, {31'h0, ms == 1});
      if (ms == 1) begin
        check("rnd_cause", {27'h0, irq_cause}, {27'h0, mcause});
        check("rnd_to_s", {31'h0, irq_to_s}, {31'h0, mtos});
      end
      check("rnd_rdata", csr_rdata,
            (asel == 0) ? mdel : (asel == 1) ? mmie : mmip);

      for (int b = 0; b < 32; b++) begin
        if (mdel[b]) okb = (priv_mode == 2'b00) || (priv_mode == 2'b01 && mstatus_sie);
        else         okb = (priv_mode != 2'b11) || mstatus_mie;
        mtake[b] = mmip[b] & mmie[b] & okb;
      end
      found = 1'b0; first = '0;
      for (int k = 0; k < 10; k++) begin
        if (!found && mtake[PRIO[k]]) begin
          found = 1'b1;
          first = 5'(PRIO[k]);
        end
      end

      if (do_rst) begin
        ms = 0; mcause = '0; mtos = 1'b0; mmie = '0; mdel = '0;
        mssip = 1'b0; mstip = 1'b0; mseip = 1'b0; mlatch = '0;
      end else begin
        case (ms)
          0: if (found) begin ms = 1; mcause = first; mtos = mdel[first]; end
          1: if (irq_ack) ms = 2; else if (!mtake[mcause]) ms = 0;
          default: ms = 0;
        endcase
        for (int i = 0; i < 4; i++)
          if (EMASK[i])
            mlatch[i] = (mlatch[i] & ~(wr && asel == 2 && !csr_wdata[16+i]))
                        | (dl[D-1][4+i] & ~dl[D][4+i]);
        if (wr && asel == 0) mdel = csr_wdata & 32'h0000_0222;
        if (wr && asel == 1) mmie = csr_wdata & 32'h000F_0AAA;
        if (wr && asel == 2) begin
          mssip = csr_wdata[1]; mstip = csr_wdata[5]; mseip = csr_wdata[9];
        end
      end

      @(posedge clk);
      #1;
      for (int k = 4; k > 0; k--) dl[k] = dl[k-1];
      if (do_rst) for (int k = 0; k < 5; k++) dl[k] = '0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_interrupt_unit.md
Name: csr_interrupt_unit

Overview:
- Machine/supervisor interrupt CSR block: owns mip, mie and mideleg, and generalises the fixed mip/mie bit layout to a parametrised number of custom interrupt lines in bits 31:16.
- Selects the highest-priority enabled pending interrupt and raises a trap request to the pipeline's trap logic.
- Holds the request stable until acknowledged.
- Sits beside the main CSR unit, which supplies privilege and mstatus MIE/SIE and forwards CSR accesses at 0x303/0x304/0x344.

Parameters:
- NUM_CUSTOM_IRQ, 4, number of custom interrupt lines; legal range 0–16; mapped to mip/mie bits 16+i.
- CUSTOM_EDGE_MASK, 16'h0000, bit i=1 makes custom line i edge-triggered (rising edge latched); bit i=0 makes it level.
- ECODE_W, 5, width of irq_cause.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- csr_wr_en  input  1  CSR write strobe
- csr_addr  input  12  CSR address
- csr_wdata  input  32  CSR write data
- csr_rdata  output  32  read data for csr_addr; 0 for unowned addresses
- priv_mode  input  2  current privilege (00 U, 01 S, 11 M)
- mstatus_mie  input  1  global M interrupt enable
- mstatus_sie  input  1  global S interrupt enable
- m_ext_irq, m_timer_irq, m_soft_irq, s_ext_irq  input  1 each  platform interrupt lines, level
- custom_irq  input  max(NUM_CUSTOM_IRQ,1)  custom lines
- irq_req  output  1  interrupt trap request
- irq_cause  output  ECODE_W  cause code of the requested interrupt
- irq_to_s  output  1  1 = trap goes to S-mode (delegated), 0 = M-mode
- irq_ack  input  1  trap logic accepted the request this cycle

Behaviour:
- Reset: mie=0, mideleg=0, writable mip bits (ssip, stip, seip, edge-latched custom bits)=0; FSM IDLE; irq_req=0, irq_cause=0, irq_to_s=0. csr_rdata is combinational.
- mip read view:
  - meip/mtip/msip mirror registered inputs and are read-only.
  - seip = s_ext_irq OR software seip bit.
  - Level custom bits mirror inputs; edge custom bits are latched.
  - Bits above 16+NUM_CUSTOM_IRQ-1 and all reserved bits read 0.
- mip writes (0x344):
  - Only ssip, stip and software seip are writable.
  - Edge custom bits are write-0-to-clear only; writing 1 has no effect.
  - If an edge arrives in the same cycle as a clear, the set wins.
- mie (0x304): writable at standard bit positions plus implemented custom bits; all others read 0.
- mideleg (0x303): only bits 1, 5 and 9 (S interrupts) are writable; M bits are hard-wired 0.
- Input sampling: inputs are registered once. A line asserted at cycle N is visible in mip at N+1; irq_req rises at N+2 at the earliest.
- Per-bit enable: active = mip & mie.
  - Non-delegated bit is taken if priv<M, or priv==M and mstatus_mie.
  - Delegated bit is taken if priv==U, or priv==S and mstatus_sie; never taken in M.
- Priority, highest first: MEI(11), MSI(3), MTI(7), SEI(9), SSI(1), STI(5), then custom 16, 17, … (lowest index highest). Cause code = bit index.
- FSM:
  - IDLE: if any interrupt is takeable → REQ; latch cause and irq_to_s; irq_req=1 from the next cycle.
  - REQ: irq_req=1; cause and irq_to_s frozen. irq_ack → HOLD and irq_req=0 in the same registered update. If the selected source disappears before ack (pending or enable drop), return to IDLE with irq_req=0 and no ack required.
  - HOLD: one-cycle holdoff so the trap's mstatus update propagates → IDLE.
- irq_ack while in IDLE or HOLD is ignored.
- A CSR write in the same cycle as selection: selection uses pre-write register values.
- rst_n low in any state: return to the reset state on the next clock; no request survives reset.

Optional Feature:
- Macro IRQ_SYNC_EN.
- Defined: m_ext_irq, m_timer_irq, m_soft_irq, s_ext_irq and custom_irq each pass through a 2-flop synchroniser before the input register. Minimum line-to-irq_req latency becomes 4 cycles. Edge detection is performed on the synchronised signal. Synchroniser flops reset to 0.
- Undefined: single input register only; 2-cycle minimum latency.

Test Plan:
- Reset, then read 0x304, 0x303 and 0x344 → all 0; irq_req=0.
- priv=11, mstatus_mie=1, mie=0x880; assert m_timer_irq and m_ext_irq together at cycle N → irq_req=1 at N+2 (N+4 with IRQ_SYNC_EN), irq_cause=11, irq_to_s=0. Pulse irq_ack → irq_req=0 the next cycle and stays 0 during HOLD.
- mideleg written with 0xFFFFFFFF → reads 0x222. priv=01, mstatus_sie=1, mie=0x200, s_ext_irq=1 → cause 9, irq_to_s=1. Switch to priv=11 with the same state → no request.
- NUM_CUSTOM_IRQ=4, CUSTOM_EDGE_MASK=16'h0002, mie bit 17 set, priv=00: one-cycle pulse on custom_irq[1] → mip bit 17 stays 1 and cause=17. Write 0 to bit 17 in the same cycle as a new edge → bit stays 1.
- In REQ with cause 7, clear mie bit 7 before ack → irq_req drops and FSM returns to IDLE; a later ack is ignored.
- Write 0xFFFFFFFF to 0x344 → read shows only bits 1, 5, 9 set (lines idle); bits 20–31 read 0.
